// File: rtl/dmem_pipelined.sv
// Pipelined data memory: word RAM behind valid/ready request and response
// channels, with byte strobes, fixed read latency and in-order responses.
// Ports: clk, rst (async active-low); req_valid/req_ready/req_write/
// req_addr/req_wdata/req_be; rsp_valid/rsp_ready/rsp_rdata/rsp_err.
// Optional macro DMEM_PARITY_EN adds per-byte even parity and the
// inj_par_err input (inverts stored parity of enabled bytes on a store).
module dmem_pipelined #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 64,
    parameter int RD_LATENCY  = 2,
    parameter int OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
`ifdef DMEM_PARITY_EN
    input  logic              inj_par_err,
`endif
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);
    localparam int NB = DATA_W / 8;
    localparam int IW = $clog2(DEPTH_WORDS);
    localparam int OW = $clog2(NB);
    localparam int CW = $clog2(OUTSTANDING + 1);
    localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int PS = RD_LATENCY - 1;
    localparam int PD = (PS > 0) ? PS : 1;
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH_WORDS * NB);
    localparam logic [ADDR_W-1:0] LMASK = ADDR_W'(NB - 1);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

    logic          acc;
    logic          pop;
    logic [IW-1:0] widx;
    logic          addr_err;
    logic          wr_ok;
    logic          par_bad;

    logic              in_v;
    logic [DATA_W-1:0] in_d;
    logic              in_e;
    logic              fin_v;
    logic [DATA_W-1:0] fin_d;
    logic              fin_e;

    logic              pv_q [PD];
    logic [DATA_W-1:0] pd_q [PD];
    logic              pe_q [PD];

    logic [DATA_W-1:0] fd_q [OUTSTANDING];
    logic              fe_q [OUTSTANDING];
    logic [PW-1:0]     wptr_q, rptr_q;
    logic [CW-1:0]     fcnt_q, fcnt_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    assign acc      = req_valid & req_ready;
    assign pop      = rsp_valid & rsp_ready;
    assign widx     = IW'(req_addr >> OW);
    assign addr_err = (|(req_addr & LMASK)) | (req_addr >= LIMIT);
    assign wr_ok    = acc & req_write & ~addr_err;

`ifdef DMEM_PARITY_EN
    logic [NB-1:0] par_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int b = 0; b < NB; b++) begin
                if (req_be[b]) begin
                    par_q[widx][b] <= (^req_wdata[8*b +: 8]) ^ inj_par_err;
                end
            end
        end
    end

    always_comb begin
        par_bad = 1'b0;
        for (int b = 0; b < NB; b++) begin
            if ((^mem_q[widx][8*b +: 8]) != par_q[widx][b]) begin
                par_bad = 1'b1;
            end
        end
    end
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int b = 0; b < NB; b++) begin
                if (req_be[b]) begin
                    mem_q[widx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    // Stores and errored loads carry zero data; a parity hit keeps raw data.
    assign in_v = acc;
    assign in_d = (!req_write && !addr_err) ? mem_q[widx] : '0;
    assign in_e = addr_err | (~req_write & par_bad);

    // RD_LATENCY-1 register stages, the FIFO write is the final stage.
    generate
        if (PS == 0) begin : g_nopipe
            assign fin_v = in_v;
            assign fin_d = in_d;
            assign fin_e = in_e;
        end else begin : g_pipe
            assign fin_v = pv_q[PS-1];
            assign fin_d = pd_q[PS-1];
            assign fin_e = pe_q[PS-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PD; i++) begin
                pv_q[i] <= 1'b0;
                pd_q[i] <= '0;
                pe_q[i] <= 1'b0;
            end
        end else begin
            pv_q[0] <= in_v;
            pd_q[0] <= in_d;
            pe_q[0] <= in_e;
            for (int i = 1; i < PS; i++) begin
                pv_q[i] <= pv_q[i-1];
                pd_q[i] <= pd_q[i-1];
                pe_q[i] <= pe_q[i-1];
            end
        end
    end

    // Response FIFO; the credit counter guarantees it cannot overflow.
    always_ff @(posedge clk) begin
        if (fin_v) begin
            fd_q[wptr_q] <= fin_d;
            fe_q[wptr_q] <= fin_e;
        end
    end

    always_comb begin
        fcnt_d = fcnt_q;
        unique case ({fin_v, pop})
            2'b10:   fcnt_d = fcnt_q + 1'b1;
            2'b01:   fcnt_d = fcnt_q - 1'b1;
            default: fcnt_d = fcnt_q;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case ({acc, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            fcnt_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (fin_v) begin
                wptr_q <= (wptr_q == PW'(OUTSTANDING - 1)) ? '0 : wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= (rptr_q == PW'(OUTSTANDING - 1)) ? '0 : rptr_q + 1'b1;
            end
            fcnt_q <= fcnt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign req_ready = (cnt_q < CW'(OUTSTANDING));
    assign rsp_valid = (fcnt_q != '0);
    assign rsp_rdata = rsp_valid ? fd_q[rptr_q] : '0;
    assign rsp_err   = rsp_valid ? fe_q[rptr_q] : 1'b0;

endmodule
